dot: RTL and testbench
======================

DOT -- requirements
Module: dot

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-high: asserted when 1, sampled on rising clk.
REQ-004 slave_address  input  4  word offset into the register map.
REQ-005 slave_read  input  1  slave read request.
REQ-006 slave_write  input  1  slave write request.
REQ-007 slave_writedata  input  32  slave write data.
REQ-008 slave_readdata  output  32  slave read data.
REQ-009 slave_waitrequest  output  1  stalls slave read until the result is ready.
REQ-010 master_address  output  32  byte address of the memory read.
REQ-011 master_read  output  1  memory read request.
REQ-012 master_waitrequest  input  1  memory stall; a read is accepted on a cycle with master_read=1 and waitrequest=0.
REQ-013 master_readdatavalid  input  1  memory read data valid.
REQ-014 master_readdata  input  32  memory read data.
REQ-015 master_write  output  1  constant 0.
REQ-016 master_writedata  output  32  constant 0.

Function
REQ-017 Register map (word offsets): 2 = weight vector byte address; 3 = input vector byte address; 5 = vector length N (elements); 0 = start / result; other offsets are ignored on write and read as 0.
REQ-018 A write to offsets 2, 3 or 5 stores slave_writedata in one cycle and never stalls.
REQ-019 A write to offset 0 with any data, while IDLE, clears the accumulator, sets index i=0, and enters FETCH_W; while busy it is ignored.
REQ-020 States: IDLE, FETCH_W, WAIT_W, FETCH_I, WAIT_I, MAC, DONE.
REQ-021 FETCH_W: master_read=1, master_address=wbase+4*i; hold until master_waitrequest=0, then go to WAIT_W.
REQ-022 WAIT_W: master_read=0; on master_readdatavalid=1 latch master_readdata as w and go to FETCH_I.
REQ-023 FETCH_I and WAIT_I: same handshake at ibase+4*i; latch a, then go to MAC.
REQ-024 Only one master read is outstanding at a time; readdatavalid is ignored outside WAIT_W and WAIT_I.
REQ-025 MAC: p = signed(w) x signed(a) as a 64-bit value (Q16.16 x Q16.16); prod = (p + 2^31) >>> 32, i.e. round to nearest integer with arithmetic shift.
REQ-026 MAC (cont.): acc = acc + prod in 32-bit two's complement, wrapping on overflow; i = i+1; go to FETCH_W if i < N, else DONE.
REQ-027 N = 0: go directly from start to DONE with result 0.
REQ-028 Slave read at offset 0 while busy (not IDLE or DONE): slave_waitrequest=1 until DONE.
REQ-029 In DONE with slave_read=1 at offset 0: slave_waitrequest=0 and slave_readdata=acc for one cycle, then IDLE.
REQ-030 DONE with no pending read: move to IDLE with the result retained.
REQ-031 Slave read at offset 0 in IDLE returns the last result with slave_waitrequest=0.
REQ-032 slave_waitrequest is 0 whenever no stalled offset-0 read is pending.

Reset
REQ-033 rst_n=1 at a rising edge forces IDLE; clears acc, i and all registers (wbase, ibase, N) to 0.
REQ-034 Output values while rst_n=1: master_read=0, master_address=0, slave_waitrequest=0, slave_readdata=0.
REQ-035 Reset mid-operation aborts immediately; no further master reads are issued; an in-flight readdatavalid is ignored.

Verification
REQ-036 Program wbase=0x03, ibase=0x12, N=3 and start; memory returns w={102236, 65536, -370934} and a={81265, -163185, 122552}. Required: per-element prod = 2, -2, -11; the held offset-0 read completes with slave_readdata=-11 (0xFFFFFFF5) and slave_waitrequest=0.
REQ-037 Same run: master_address sequence 0x03, 0x12, 0x07, 0x16, 0x0B, 0x1A; each read is held while master_waitrequest=1.
REQ-038 N=0 and start: the offset-0 read returns 0 with no master_read pulse.
REQ-039 Write to offset 0 during a computation: ignored; the result is unchanged (-11 for the REQ-036 data).
REQ-040 Assert reset during WAIT_I: master_read=0 the next cycle; a following offset-0 read returns 0 without a stall.

Source files
------------

// File: rtl/dot.sv
// Fixed-point Q16.16 dot product engine: slave register interface, single-outstanding memory master.
// A held offset-0 slave read stalls until the result is available.
module dot (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   output logic [31:0] slave_readdata,
   output logic        slave_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic        master_waitrequest,
   input  logic        master_readdatavalid,
   input  logic [31:0] master_readdata,
   output logic        master_write,
   output logic [31:0] master_writedata
);

   typedef enum logic [2:0] {
      StIdle, StFetchW, StWaitW, StFetchI, StWaitI, StMac, StDone
   } state_t;

   state_t      state;
   logic [31:0] wbase, ibase, len;
   logic [31:0] acc, idx, w, a;
   logic        mr_q;
   logic [31:0] ma_q;

   logic [63:0] p, rnd;
   logic [31:0] prod, idx_nxt;
   logic        busy, start;
   logic        unused_rnd_lo;

   // Low 64 bits of the sign-extended product equal the signed 64-bit product.
   assign p             = {{32{w[31]}}, w} * {{32{a[31]}}, a};
   assign rnd           = p + 64'h0000_0000_8000_0000;
   assign prod          = rnd[63:32];
   assign unused_rnd_lo = ^rnd[31:0];
   assign idx_nxt       = idx + 32'd1;
   assign busy          = (state != StIdle) && (state != StDone);
   assign start         = slave_write && (slave_address == 4'd0);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= StIdle;
         wbase <= '0;
         ibase <= '0;
         len   <= '0;
         acc   <= '0;
         idx   <= '0;
         w     <= '0;
         a     <= '0;
         mr_q  <= 1'b0;
         ma_q  <= '0;
      end else begin
         if (slave_write) begin
            case (slave_address)
               4'd2:    wbase <= slave_writedata;
               4'd3:    ibase <= slave_writedata;
               4'd5:    len   <= slave_writedata;
               default: ;
            endcase
         end
         case (state)
            StIdle: begin
               if (start) begin
                  acc <= '0;
                  idx <= '0;
                  if (len == 32'd0) begin
                     state <= StDone;
                  end else begin
                     state <= StFetchW;
                     mr_q  <= 1'b1;
                     ma_q  <= wbase;
                  end
               end
            end
            StFetchW: begin
               if (!master_waitrequest) begin
                  mr_q  <= 1'b0;
                  state <= StWaitW;
               end
            end
            StWaitW: begin
               if (master_readdatavalid) begin
                  w     <= master_readdata;
                  state <= StFetchI;
                  mr_q  <= 1'b1;
                  ma_q  <= ibase + {idx[29:0], 2'b00};
               end
            end
            StFetchI: begin
               if (!master_waitrequest) begin
                  mr_q  <= 1'b0;
                  state <= StWaitI;
               end
            end
            StWaitI: begin
               if (master_readdatavalid) begin
                  a     <= master_readdata;
                  state <= StMac;
               end
            end
            StMac: begin
               acc <= acc + prod;
               idx <= idx_nxt;
               if (idx_nxt < len) begin
                  state <= StFetchW;
                  mr_q  <= 1'b1;
                  ma_q  <= wbase + {idx_nxt[29:0], 2'b00};
               end else begin
                  state <= StDone;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   // Slave responses are combinational so a stalled read completes in the DONE cycle.
   always_comb begin
      slave_readdata    = '0;
      slave_waitrequest = 1'b0;
      if (!rst_n && slave_read) begin
         case (slave_address)
            4'd0: begin
               slave_waitrequest = busy;
               slave_readdata    = busy ? 32'd0 : acc;
            end
            4'd2:    slave_readdata = wbase;
            4'd3:    slave_readdata = ibase;
            4'd5:    slave_readdata = len;
            default: slave_readdata = '0;
         endcase
      end
   end

   assign master_read      = mr_q & ~rst_n;
   assign master_address   = rst_n ? 32'd0 : ma_q;
   assign master_write     = 1'b0;
   assign master_writedata = '0;

endmodule

// File: tb/tb_dot.sv
// Directed bench for dot: slave register access, three-element MAC, N=0, busy start and reset abort.
// A reactive memory model stalls every read two cycles and returns data two cycles after accept.
module tb_dot;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  slave_address;
   logic        slave_read, slave_write;
   logic [31:0] slave_writedata, slave_readdata;
   logic        slave_waitrequest;
   logic [31:0] master_address;
   logic        master_read;
   logic        master_waitrequest = 1'b0;
   logic        master_readdatavalid = 1'b0;
   logic [31:0] master_readdata = '0;
   logic        master_write;
   logic [31:0] master_writedata;

   int checks = 0;
   int errors = 0;

   logic [31:0] addr_log[$];
   int          held = 0, moved = 0, wait_cnt = 0, pend_cnt = 0, mr_cycles = 0;
   logic [31:0] pend_addr = '0, hold_addr = '0;

   always #5 clk = ~clk;

   dot u_dot (
      .clk                  (clk),
      .rst_n                (rst_n),
      .slave_address        (slave_address),
      .slave_read           (slave_read),
      .slave_write          (slave_write),
      .slave_writedata      (slave_writedata),
      .slave_readdata       (slave_readdata),
      .slave_waitrequest    (slave_waitrequest),
      .master_address       (master_address),
      .master_read          (master_read),
      .master_waitrequest   (master_waitrequest),
      .master_readdatavalid (master_readdatavalid),
      .master_readdata      (master_readdata),
      .master_write         (master_write),
      .master_writedata     (master_writedata)
   );

   function automatic logic [31:0] mem(input logic [31:0] addr);
      case (addr)
         32'h03:  return 32'd102236;
         32'h07:  return 32'd65536;
         32'h0B:  return -32'sd370934;
         32'h12:  return 32'd81265;
         32'h16:  return -32'sd163185;
         32'h1A:  return 32'd122552;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Memory model: two stall cycles per read, data valid two cycles after accept.
   always @(negedge clk) begin
      master_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         if (pend_cnt == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mem(pend_addr);
         end
      end
      if (master_read) begin
         mr_cycles = mr_cycles + 1;
         if (wait_cnt == 0) hold_addr = master_address;
         else if (master_address != hold_addr) moved = moved + 1;
         if (wait_cnt < 2) begin
            master_waitrequest = 1'b1;
            wait_cnt           = wait_cnt + 1;
            held               = held + 1;
         end else begin
            master_waitrequest = 1'b0;
            wait_cnt           = 0;
            addr_log.push_back(master_address);
            pend_addr = master_address;
            pend_cnt  = 2;
         end
      end else begin
         master_waitrequest = 1'b0;
         wait_cnt           = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      @(negedge clk);
      slave_address   = addr;
      slave_writedata = data;
      slave_write     = 1'b1;
      @(negedge clk);
      slave_write     = 1'b0;
   endtask

   task automatic rd(input logic [3:0] addr, output logic [31:0] data, output int stalls,
                     output logic ok);
      @(negedge clk);
      slave_address = addr;
      slave_read    = 1'b1;
      stalls        = 0;
      ok            = 1'b0;
      data          = 'x;
      for (int k = 0; k < 500; k++) begin
         #1;
         if (!slave_waitrequest) begin
            data = slave_readdata;
            ok   = 1'b1;
            break;
         end
         stalls = stalls + 1;
         @(negedge clk);
      end
      @(negedge clk);
      slave_read = 1'b0;
   endtask

   logic [31:0] d;
   int          s, m0;
   logic        ok;
   logic [31:0] exp_addr[6];

   initial begin
      exp_addr = '{32'h03, 32'h12, 32'h07, 32'h16, 32'h0B, 32'h1A};
      rst_n = 1'b1;
      slave_address = '0;
      slave_read = 1'b0;
      slave_write = 1'b0;
      slave_writedata = '0;

      // Reset outputs with a live offset-0 read
      @(negedge clk);
      slave_read = 1'b1;
      @(posedge clk);
      #1;
      check("rst_master_read", {31'd0, master_read}, 32'd0);
      check("rst_master_address", master_address, 32'd0);
      check("rst_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
      check("rst_readdata", slave_readdata, 32'd0);
      @(negedge clk);
      slave_read = 1'b0;
      rst_n = 1'b0;

      wr(4'd2, 32'h03);
      wr(4'd3, 32'h12);
      wr(4'd5, 32'd1);
      rd(4'd2, d, s, ok);
      check("reg_wbase", d, 32'h03);
      rd(4'd3, d, s, ok);
      check("reg_ibase", d, 32'h12);
      rd(4'd5, d, s, ok);
      check("reg_len", d, 32'd1);

      // N=1: 102236*81265 rounds to 2
      wr(4'd0, 32'd0);
      rd(4'd0, d, s, ok);
      check("n1_ok", {31'd0, ok}, 32'd1);
      check("n1_result", d, 32'd2);
      check("n1_stalled", {31'd0, s > 0}, 32'd1);

      // N=2: 2 + (-2)
      wr(4'd5, 32'd2);
      wr(4'd0, 32'd0);
      rd(4'd0, d, s, ok);
      check("n2_result", d, 32'd0);

      // N=3: 2 - 2 - 11
      wr(4'd5, 32'd3);
      addr_log.delete();
      held = 0;
      moved = 0;
      wr(4'd0, 32'd0);
      rd(4'd0, d, s, ok);
      check("n3_ok", {31'd0, ok}, 32'd1);
      check("n3_result", d, 32'hFFFF_FFF5);
      check("n3_nreads", addr_log.size(), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < addr_log.size()) check($sformatf("n3_addr%0d", k), addr_log[k], exp_addr[k]);
      end
      check("n3_held_cycles", held, 32'd12);
      check("n3_addr_stable", moved, 32'd0);

      // Start while busy is ignored
      addr_log.delete();
      wr(4'd0, 32'd0);
      repeat (8) @(negedge clk);
      wr(4'd0, 32'd0);
      rd(4'd0, d, s, ok);
      check("busy_start_result", d, 32'hFFFF_FFF5);
      check("busy_start_nreads", addr_log.size(), 32'd6);

      // N=0: immediate zero result, no memory traffic
      wr(4'd5, 32'd0);
      m0 = mr_cycles;
      wr(4'd0, 32'd0);
      rd(4'd0, d, s, ok);
      check("n0_ok", {31'd0, ok}, 32'd1);
      check("n0_result", d, 32'd0);
      check("n0_no_stall", s, 32'd0);
      check("n0_no_master_read", mr_cycles - m0, 32'd0);

      // Reset while waiting for input data
      wr(4'd5, 32'd3);
      addr_log.delete();
      wr(4'd0, 32'd0);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         #1;
         if (addr_log.size() >= 2) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_reached_wait_i", {31'd0, ok}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_master_read", {31'd0, master_read}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      m0 = mr_cycles;
      repeat (10) @(negedge clk);
      check("abort_no_more_reads", mr_cycles - m0, 32'd0);
      rd(4'd0, d, s, ok);
      check("abort_result", d, 32'd0);
      check("abort_no_stall", s, 32'd0);
      rd(4'd5, d, s, ok);
      check("abort_len_cleared", d, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
